// File: rtl/mem_port_sched_if.sv
// Handshake bundle between the memory port scheduler, its two requesters
// (fetch and data path) and the unified memory.
interface mem_port_sched_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;

    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;

    logic          stall_if;
    logic          stall_dm;
    logic          halt;
    logic          halted;
    logic          err;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;

    // Scheduler side
    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt,
               mem_rdata, mem_done,
        output if_valid, if_rdata, dm_valid, dm_rdata, stall_if, stall_dm,
               halted, err, mem_en, mem_wr, mem_addr, mem_wdata
    );

    // Requester and memory side
    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt,
               mem_rdata, mem_done,
        input  if_valid, if_rdata, dm_valid, dm_rdata, stall_if, stall_dm,
               halted, err, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler: data path has absolute priority over fetch,
// accesses abort on timeout, and halt drains outstanding work before parking.
module mem_port_sched #(
    parameter int TIMEOUT = 15,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input logic             clk,
    input logic             rst_n,
    mem_port_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DATA, FETCH, RESP, HALTED} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e        state_q;
    logic          mem_en_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          if_valid_q;
    logic [DW-1:0] if_rdata_q;
    logic          dm_valid_q;
    logic [DW-1:0] dm_rdata_q;
    logic          halted_q;
    logic          err_q;
    logic          halt_pend_q;
    logic [7:0]    cnt_q;
    logic [7:0]    cnt_d;

    assign cnt_d = cnt_q + 8'd1;

    // A halt seen mid-access is remembered so that it takes effect once the
    // scheduler is back in IDLE with no legal data request waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (state_q != HALTED && bus.halt) begin
                halt_pend_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.dm_rd ^ bus.dm_wr) begin
                        state_q     <= DATA;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= bus.dm_wr;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        cnt_q       <= '0;
                    end else if (bus.dm_rd && bus.dm_wr) begin
                        err_q <= 1'b1;
                    end else if (bus.halt || halt_pend_q) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (bus.if_req) begin
                        state_q    <= FETCH;
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                        cnt_q      <= '0;
                    end
                end
                DATA, FETCH: begin
                    if (bus.mem_done) begin
                        state_q  <= RESP;
                        mem_en_q <= 1'b0;
                        if (state_q == DATA) begin
                            dm_rdata_q <= bus.mem_rdata;
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end else if (cnt_d == TimeoutCnt) begin
                        // Abandoned access still completes with zero data so
                        // the requester is never left hanging.
                        state_q  <= RESP;
                        mem_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        if (state_q == DATA) begin
                            dm_rdata_q <= '0;
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= '0;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                HALTED: begin
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.halted    = halted_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_valid;
    assign bus.stall_dm  = (bus.dm_rd | bus.dm_wr) & ~bus.dm_valid;
endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: directed scenarios plus random traffic, checked
// against a transaction-level memory model and latency arithmetic.
module tb_mem_port_sched;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] refMem [logic [15:0]];
    logic [15:0] devMem [logic [15:0]];

    mem_port_sched_if #(.AW(16), .DW(16)) bus ();

    mem_port_sched #(.TIMEOUT(TIMEOUT), .AW(16), .DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of a never-written location, shared by the device and the model
    function automatic logic [15:0] initWord(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initWord(a);
    endfunction

    function automatic logic [15:0] devRead(input logic [15:0] a);
        if (devMem.exists(a)) return devMem[a];
        return initWord(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One access from request to valid. kind: 0 = load, 1 = store, 2 = fetch.
    // lat = cycles of mem_en before mem_done (0 = memory never answers).
    // withFetch raises if_req together with the data request and keeps it up.
    task automatic applyStimulus(input int kind, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int lat,
                                 input bit withFetch, input logic [15:0] fAddr,
                                 input int haltAt);
        bit          isData;
        bit          timedOut;
        int          expLen;
        int          enCycles;
        int          validCycle;
        int          otherValid;
        logic [15:0] expData;
        isData   = (kind != 2);
        timedOut = (lat == 0) || (lat > TIMEOUT);
        expLen   = timedOut ? TIMEOUT : lat;
        expData  = timedOut ? 16'h0000 : refRead(addr);
        if (kind == 1) refMem[addr] = wdata;
        enCycles   = 0;
        validCycle = -1;
        otherValid = 0;

        @(posedge clk); #1;
        if (isData) begin
            bus.dm_rd    = (kind == 0);
            bus.dm_wr    = (kind == 1);
            bus.dm_addr  = addr;
            bus.dm_wdata = wdata;
            if (withFetch) begin
                bus.if_req  = 1'b1;
                bus.if_addr = fAddr;
            end
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        #1;
        checkOutput(isData ? "stall_dm_c0" : "stall_if_c0",
                    isData ? 32'(bus.stall_dm) : 32'(bus.stall_if), 32'd1);
        if (withFetch) checkOutput("stall_if_contend", 32'(bus.stall_if), 32'd1);

        for (int c = 1; c <= 60 && validCycle < 0; c++) begin
            @(posedge clk); #1;
            bus.mem_done = 1'b0;
            bus.halt     = (c == haltAt);
            if (c == 1) begin
                checkOutput("mem_en_c1", 32'(bus.mem_en), 32'd1);
                checkOutput("mem_addr_c1", 32'(bus.mem_addr), 32'(addr));
                checkOutput("mem_wr_c1", 32'(bus.mem_wr), (kind == 1) ? 32'd1 : 32'd0);
                if (kind == 1) checkOutput("mem_wdata_c1", 32'(bus.mem_wdata), 32'(wdata));
            end
            if (bus.mem_en === 1'b1) begin
                enCycles++;
                if (lat != 0 && enCycles == lat) begin
                    bus.mem_done  = 1'b1;
                    bus.mem_rdata = devRead(bus.mem_addr);
                    if (bus.mem_wr === 1'b1) devMem[bus.mem_addr] = bus.mem_wdata;
                end
            end
            if ((isData ? bus.if_valid : bus.dm_valid) === 1'b1) otherValid++;
            if ((isData ? bus.dm_valid : bus.if_valid) === 1'b1) begin
                validCycle = c;
                if (kind != 1 || timedOut)
                    checkOutput("rdata", isData ? 32'(bus.dm_rdata) : 32'(bus.if_rdata),
                                32'(expData));
                if (isData) begin
                    bus.dm_rd = 1'b0;
                    bus.dm_wr = 1'b0;
                end else begin
                    bus.if_req = 1'b0;
                end
            end
        end
        bus.halt     = 1'b0;
        bus.mem_done = 1'b0;
        if (validCycle < 0) begin
            bus.dm_rd  = 1'b0;
            bus.dm_wr  = 1'b0;
            bus.if_req = 1'b0;
        end
        checkOutput("valid_cycle", 32'(validCycle), 32'(expLen + 1));
        checkOutput("mem_en_cycles", 32'(enCycles), 32'(expLen));
        checkOutput("no_other_valid", 32'(otherValid), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_valids"}, {30'd0, bus.if_valid, bus.dm_valid}, 32'd0);
        checkOutput({tag, "_halted"}, 32'(bus.halted), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checkResetState("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          kind;
        int          lat;
        int          enCount;
        logic [15:0] a;
        logic [15:0] fa;
        logic [15:0] d;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_rd     = 1'b0;
        bus.dm_wr     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.halt      = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_done  = 1'b0;

        #12;
        checkResetState("por");
        checkOutput("por_stall", {30'd0, bus.stall_if, bus.stall_dm}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] directed load");
        refMem[16'h0040] = 16'hBEEF;
        devMem[16'h0040] = 16'hBEEF;
        applyStimulus(0, 16'h0040, 16'h0000, 2, 1'b0, 16'h0000, -1);

        $display("[TB] store contending with fetch");
        applyStimulus(1, 16'h0100, 16'h1234, 3, 1'b1, 16'h0010, -1);
        applyStimulus(2, 16'h0010, 16'h0000, 2, 1'b0, 16'h0000, -1);
        applyStimulus(0, 16'h0100, 16'h0000, 1, 1'b0, 16'h0000, -1);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            lat  = int'($urandom_range(1, 6));
            a    = 16'($urandom_range(0, 7)) << 1;
            fa   = 16'h0200 + (16'($urandom_range(0, 7)) << 1);
            d    = 16'($urandom);
            if (kind == 3) begin
                applyStimulus(int'($urandom_range(0, 1)), a, d, lat, 1'b1, fa, -1);
                applyStimulus(2, fa, 16'h0000, int'($urandom_range(1, 6)), 1'b0, 16'h0000, -1);
            end else begin
                applyStimulus(kind, (kind == 2) ? fa : a, d, lat, 1'b0, 16'h0000, -1);
            end
        end
        checkOutput("err_clean", 32'(bus.err), 32'd0);

        $display("[TB] halt during fetch");
        applyStimulus(2, 16'h0300, 16'h0000, 3, 1'b0, 16'h0000, 1);
        @(posedge clk); #1;
        checkOutput("halted_idle", 32'(bus.halted), 32'd0);
        @(posedge clk); #1;
        checkOutput("halted_set", 32'(bus.halted), 32'd1);
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0302;
        enCount     = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.mem_en !== 1'b0) enCount++;
        end
        checkOutput("halted_no_fetch", 32'(enCount), 32'd0);
        checkOutput("halted_stall_if", 32'(bus.stall_if), 32'd1);
        checkOutput("halted_stays", 32'(bus.halted), 32'd1);
        bus.if_req = 1'b0;
        doReset();

        $display("[TB] illegal simultaneous read/write");
        @(posedge clk); #1;
        bus.dm_rd   = 1'b1;
        bus.dm_wr   = 1'b1;
        bus.dm_addr = 16'h0044;
        enCount     = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.mem_en !== 1'b0) enCount++;
        end
        checkOutput("illegal_no_mem_en", 32'(enCount), 32'd0);
        checkOutput("illegal_err", 32'(bus.err), 32'd1);
        checkOutput("illegal_stall_dm", 32'(bus.stall_dm), 32'd1);
        bus.dm_rd = 1'b0;
        bus.dm_wr = 1'b0;
        doReset();

        $display("[TB] memory timeout");
        applyStimulus(0, 16'h0046, 16'h0000, 0, 1'b0, 16'h0000, -1);
        checkOutput("timeout_err", 32'(bus.err), 32'd1);
        applyStimulus(0, 16'h0040, 16'h0000, 2, 1'b0, 16'h0000, -1);
        checkOutput("err_sticky", 32'(bus.err), 32'd1);
        doReset();

        $display("[TB] reset mid-access");
        @(posedge clk); #1;
        bus.dm_rd   = 1'b1;
        bus.dm_addr = 16'h0048;
        @(posedge clk); #1;
        checkOutput("mid_mem_en_before", 32'(bus.mem_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("mid");
        bus.dm_rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(0, 16'h0040, 16'h0000, 1, 1'b0, 16'h0000, -1);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
